// File: rtl/traffic_pkg.sv
// Shared light codes, phase encoding and timer width for the intersection scheduler.
// Pure declarations: no logic and no latency.
package traffic_pkg;

  localparam int TIMER_W = 5;

  localparam logic [1:0] OFF    = 2'b00;
  localparam logic [1:0] RED    = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] YELLOW = 2'b11;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_M   = 3'd2,
    PED_WALK    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_S   = 3'd6
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that steps once per tick; expire flags the last tick of a phase.
// Count updates one clk after load/tick; expire is combinational from the tick input.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [TIMER_W-1:0] RST_VAL = 5'd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick,
  input  logic               hold,
  output logic [TIMER_W-1:0] count,
  output logic               expire
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && !hold && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = tick && (count_q == 5'd1);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Main/side intersection sequencer with a pedestrian crossing over main, timed by a 1 Hz tick.
// Lights decode directly from the state register; state and timer advance only on tick.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int T_MAIN_GREEN = 10,
  parameter int T_MAIN_MIN   = 4,
  parameter int T_YELLOW     = 3,
  parameter int T_ALL_RED    = 1,
  parameter int T_SIDE_GREEN = 8,
  parameter int T_WALK       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_btn,
  input  logic       side_car,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] phase,
  output logic [4:0] time_left
);

  localparam logic [TIMER_W-1:0] CUT_LEVEL = TIMER_W'(T_MAIN_GREEN - T_MAIN_MIN);

  state_e             state_q, state_d;
  logic               ped_btn_q, ped_btn_d;
  logic               ped_pending_q, ped_pending_d;
  logic               load;
  logic               hold;
  logic               expire;
  logic [TIMER_W-1:0] load_val;
  logic [TIMER_W-1:0] count;

  function automatic logic [TIMER_W-1:0] phase_dur(input state_e s);
    case (s)
      MAIN_GREEN:  phase_dur = TIMER_W'(T_MAIN_GREEN);
      MAIN_YELLOW: phase_dur = TIMER_W'(T_YELLOW);
      PED_WALK:    phase_dur = TIMER_W'(T_WALK);
      SIDE_GREEN:  phase_dur = TIMER_W'(T_SIDE_GREEN);
      SIDE_YELLOW: phase_dur = TIMER_W'(T_YELLOW);
      default:     phase_dur = TIMER_W'(T_ALL_RED);
    endcase
  endfunction

  phase_timer #(
    .RST_VAL(TIMER_W'(T_ALL_RED))
  ) u_timer (
    .clk     (clk),
    .rst     (reset),
    .load    (load),
    .load_val(load_val),
    .tick    (tick),
    .hold    (hold),
    .count   (count),
    .expire  (expire)
  );

  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    case (state_q)
      MAIN_GREEN: begin
        // A latched ped request may cut main green once the minimum has run.
        if (tick && ped_pending_q && (count <= CUT_LEVEL)) begin
          state_d = MAIN_YELLOW;
        end else if (expire) begin
          if (side_car) state_d = MAIN_YELLOW;
          else          hold    = 1'b1;
        end
      end
      MAIN_YELLOW: if (expire) state_d = ALL_RED_M;
      ALL_RED_M: begin
        if (expire) begin
          if (ped_pending_q) state_d = PED_WALK;
          else if (side_car) state_d = SIDE_GREEN;
          else               state_d = MAIN_GREEN;
        end
      end
      PED_WALK:    if (expire) state_d = side_car ? SIDE_GREEN : ALL_RED_S;
      SIDE_GREEN:  if (expire) state_d = SIDE_YELLOW;
      SIDE_YELLOW: if (expire) state_d = ALL_RED_S;
      ALL_RED_S:   if (expire) state_d = MAIN_GREEN;
      default:     state_d = ALL_RED_S;
    endcase

    load     = (state_d != state_q);
    load_val = phase_dur(state_d);

    // A new press in the same clk as walk entry survives the clear.
    ped_btn_d     = ped_btn;
    ped_pending_d = (ped_btn && !ped_btn_q) ||
                    (ped_pending_q && !(load && (state_d == PED_WALK)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ALL_RED_S;
      ped_btn_q     <= 1'b0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_btn_q     <= ped_btn_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    main_light = RED;
    side_light = RED;
    case (state_q)
      MAIN_GREEN:  main_light = GREEN;
      MAIN_YELLOW: main_light = YELLOW;
      SIDE_GREEN:  side_light = GREEN;
      SIDE_YELLOW: side_light = YELLOW;
      default: ;
    endcase
  end

  assign ped_walk    = (state_q == PED_WALK);
  assign ped_pending = ped_pending_q;
  assign phase       = state_q;
  assign time_left   = count;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus randomized traffic,
// all checked each clk against a phase/remaining-ticks reference model.
module tb_traffic_phase_scheduler;

  localparam int TMG  = 10;
  localparam int TMIN = 4;
  localparam int TY   = 3;
  localparam int TAR  = 1;
  localparam int TSG  = 8;
  localparam int TW   = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ped_btn = 1'b0;
  logic       side_car = 1'b0;
  logic [1:0] main_light, side_light;
  logic       ped_walk, ped_pending;
  logic [2:0] phase;
  logic [4:0] time_left;

  int checks = 0;
  int failures = 0;

  // Reference model: phase number, ticks remaining, latched request, button history.
  int m_ph, m_rem;
  bit m_pend, m_prev;

  traffic_phase_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .ped_btn    (ped_btn),
    .side_car   (side_car),
    .main_light (main_light),
    .side_light (side_light),
    .ped_walk   (ped_walk),
    .ped_pending(ped_pending),
    .phase      (phase),
    .time_left  (time_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      0:       return TMG;
      1, 5:    return TY;
      3:       return TW;
      4:       return TSG;
      default: return TAR;
    endcase
  endfunction

  function automatic int exp_main(input int p);
    return (p == 0) ? 2 : (p == 1) ? 3 : 1;
  endfunction

  function automatic int exp_side(input int p);
    return (p == 4) ? 2 : (p == 5) ? 3 : 1;
  endfunction

  task automatic model_reset();
    m_ph = 6; m_rem = TAR; m_pend = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit t, input bit b, input bit s);
    int nxt;
    bit eb;
    eb = b && !m_prev;
    m_prev = b;
    nxt = m_ph;
    if (t) begin
      case (m_ph)
        0: if ((m_pend && m_rem <= TMG - TMIN) || (m_rem == 1 && s)) nxt = 1;
        1: if (m_rem == 1) nxt = 2;
        2: if (m_rem == 1) nxt = m_pend ? 3 : (s ? 4 : 0);
        3: if (m_rem == 1) nxt = s ? 4 : 6;
        4: if (m_rem == 1) nxt = 5;
        5: if (m_rem == 1) nxt = 6;
        default: if (m_rem == 1) nxt = 0;
      endcase
      if (nxt != m_ph) m_rem = dur(nxt);
      else if (!(m_ph == 0 && m_rem == 1)) m_rem--;
    end
    if (eb) m_pend = 1;
    else if (nxt == 3 && m_ph != 3) m_pend = 0;
    m_ph = nxt;
  endtask

  task automatic compare_all();
    check("phase", phase, m_ph);
    check("time_left", time_left, m_rem);
    check("main_light", main_light, exp_main(m_ph));
    check("side_light", side_light, exp_side(m_ph));
    check("ped_walk", ped_walk, (m_ph == 3) ? 1 : 0);
    check("ped_pending", ped_pending, m_pend);
    check("safety", (main_light != 2'b01 && side_light != 2'b01) ? 1 : 0, 0);
  endtask

  // Called just after a negedge; inputs are registered on the following posedge.
  task automatic step(input bit t, input bit b, input bit s);
    tick = t; ped_btn = b; side_car = s;
    model_step(t, b, s);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_tick(input bit b, input bit s);
    step(1'b1, b, s);
    step(1'b0, b, s);
  endtask

  task automatic apply_reset();
    reset = 1'b1; tick = 1'b0; ped_btn = 1'b0; side_car = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    check("rst_phase", phase, 6);
    check("rst_time_left", time_left, TAR);
    check("rst_main", main_light, 1);
    check("rst_side", side_light, 1);
    check("rst_walk", ped_walk, 0);
    check("rst_pending", ped_pending, 0);
    reset = 1'b0;
  endtask

  initial begin
    int seg_ph[6];
    int seg_n[6];
    int exp_q[$];
    bit lt, t, b, s;

    // 1: no demand -> rest in main green with time_left pinned at 1
    apply_reset();
    repeat (20) do_tick(1'b0, 1'b0);
    check("t1_phase", phase, 0);
    check("t1_time_left", time_left, 1);

    // 2: side car present from reset, exact per-tick phase sequence
    apply_reset();
    seg_ph = '{0, 1, 2, 4, 5, 6};
    seg_n  = '{TMG, TY, TAR, TSG, TY, TAR};
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < seg_n[i]; j++) exp_q.push_back(seg_ph[i]);
    exp_q.push_back(0);
    foreach (exp_q[k]) begin
      do_tick(1'b0, 1'b1);
      check("t2_seq", phase, exp_q[k]);
    end

    // 3/4: ped press at main-green tick 2, early cut, press on walk entry, second walk
    apply_reset();
    do_tick(1'b0, 1'b0);
    do_tick(1'b1, 1'b0);
    check("t3_pending", ped_pending, 1);
    repeat (4) do_tick(1'b0, 1'b0);
    check("t3_cut", phase, 1);
    repeat (3) do_tick(1'b0, 1'b0);
    do_tick(1'b1, 1'b0);
    check("t4_walk_phase", phase, 3);
    check("t4_walk", ped_walk, 1);
    check("t4_pending_kept", ped_pending, 1);
    repeat (6) do_tick(1'b0, 1'b0);
    check("t4_all_red_s", phase, 6);
    do_tick(1'b0, 1'b0);
    check("t4_main", phase, 0);
    repeat (5) do_tick(1'b0, 1'b0);
    check("t4_cut", phase, 1);
    repeat (4) do_tick(1'b0, 1'b0);
    check("t3_walk2", phase, 3);
    check("t3_pending_clr", ped_pending, 0);

    // 5: reset during side green with a pending request
    apply_reset();
    repeat (15) do_tick(1'b0, 1'b1);
    check("t5_side_green", phase, 4);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("t5_pending", ped_pending, 1);
    apply_reset();

    // 6: no tick for 100 clks in main yellow
    repeat (11) do_tick(1'b0, 1'b1);
    check("t6_yellow", phase, 1);
    repeat (100) step(1'b0, 1'b0, 1'b1);
    check("t6_phase", phase, 1);
    check("t6_time_left", time_left, TY);

    // Randomized traffic, ticks never wider than one clk
    apply_reset();
    lt = 0; b = 0; s = 0;
    repeat (4000) begin
      if ($urandom_range(0, 1499) == 0) begin
        apply_reset();
        b = 0; s = 0; lt = 0;
      end
      t = !lt && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) b = !b;
      if ($urandom_range(0, 15) == 0) s = !s;
      step(t, b, s);
      lt = t;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
